// File: rtl/sdram_ctrl.sv
// Two-port SDRAM controller with round-robin arbitration, single-beat reads/writes
// and periodic auto-refresh. Banks/rows are assumed open; no precharge or mode-set.
module sdram_ctrl #(
  parameter int unsigned INIT_CYCLES      = 100,
  parameter int unsigned REFRESH_INTERVAL = 780,
  parameter int unsigned REFRESH_CYCLES   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [14:0] p0_addr,
  input  logic [15:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_rvalid,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [14:0] p1_addr,
  input  logic [15:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_rvalid,
  output logic [15:0] rdata,
  output logic [12:0] sdram_a,
  output logic [1:0]  sdram_ba,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic        sdram_cke,
  output logic [1:0]  sdram_dm,
  inout  wire  [15:0] sdram_dq
);

  localparam int unsigned InitW = $clog2(INIT_CYCLES + 1);
  localparam int unsigned RefW  = $clog2(REFRESH_INTERVAL + 1);
  localparam int unsigned RcW   = $clog2(REFRESH_CYCLES + 1);

  localparam logic [InitW-1:0] InitLast = InitW'(INIT_CYCLES - 1);
  localparam logic [RefW-1:0]  RefLast  = RefW'(REFRESH_INTERVAL - 1);
  localparam logic [RcW-1:0]   RcLast   = RcW'(REFRESH_CYCLES - 1);

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CmdNop     = 4'b1111;
  localparam logic [3:0] CmdWrite   = 4'b0100;
  localparam logic [3:0] CmdRead    = 4'b0101;
  localparam logic [3:0] CmdRefresh = 4'b0001;

  typedef enum logic [2:0] {StInit, StIdle, StWrite, StRead1, StRead2, StRefresh} state_e;

  state_e           state;
  logic [InitW-1:0] init_cnt;
  logic [RefW-1:0]  ref_cnt;
  logic [RcW-1:0]   rf_cnt;
  logic             refresh_pending;
  logic             last_p1;
  logic             cur_p1;
  logic             dq_oe;
  logic             cke;
  logic [3:0]       cmd;
  logic [14:0]      adr;
  logic [15:0]      wdata_r;
  logic [15:0]      rdata_r;
  logic             ack0, ack1, rv0, rv1;
  logic             grant0, grant1;

  // Port 0 wins when alone or when port 1 was granted last.
  always_comb begin
    grant0 = p0_req && (!p1_req || last_p1);
    grant1 = p1_req && !grant0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= StInit;
      init_cnt        <= '0;
      ref_cnt         <= '0;
      rf_cnt          <= '0;
      refresh_pending <= 1'b0;
      last_p1         <= 1'b1;
      cur_p1          <= 1'b0;
      dq_oe           <= 1'b0;
      cke             <= 1'b0;
      cmd             <= CmdNop;
      adr             <= '0;
      wdata_r         <= '0;
      rdata_r         <= '0;
      ack0            <= 1'b0;
      ack1            <= 1'b0;
      rv0             <= 1'b0;
      rv1             <= 1'b0;
    end else begin
      cke   <= 1'b1;
      cmd   <= CmdNop;
      dq_oe <= 1'b0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      rv0   <= 1'b0;
      rv1   <= 1'b0;
      unique case (state)
        StInit: begin
          if (init_cnt == InitLast) begin
            state   <= StIdle;
            ref_cnt <= '0;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        StIdle: begin
          if (refresh_pending) begin
            state           <= StRefresh;
            refresh_pending <= 1'b0;
            rf_cnt          <= '0;
            cmd             <= CmdRefresh;
          end else if (grant0 || grant1) begin
            cur_p1  <= grant1;
            last_p1 <= grant1;
            ack0    <= grant0;
            ack1    <= grant1;
            adr     <= grant1 ? p1_addr : p0_addr;
            wdata_r <= grant1 ? p1_wdata : p0_wdata;
            if (grant1 ? p1_we : p0_we) begin
              state <= StWrite;
              cmd   <= CmdWrite;
              dq_oe <= 1'b1;
            end else begin
              state <= StRead1;
              cmd   <= CmdRead;
            end
          end
        end
        StWrite: state <= StIdle;
        StRead1: begin
          state <= StRead2;
          cmd   <= CmdRead;
        end
        StRead2: begin
          state   <= StIdle;
          rdata_r <= sdram_dq;
          rv0     <= !cur_p1;
          rv1     <= cur_p1;
        end
        StRefresh: begin
          if (rf_cnt == RcLast) state <= StIdle;
          else rf_cnt <= rf_cnt + 1'b1;
        end
        default: state <= StInit;
      endcase
      // Placed after the FSM so a wrap on the refresh-entry edge is not lost.
      if (state != StInit) begin
        if (ref_cnt == RefLast) begin
          ref_cnt         <= '0;
          refresh_pending <= 1'b1;
        end else begin
          ref_cnt <= ref_cnt + 1'b1;
        end
      end
    end
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  assign sdram_ba  = adr[14:13];
  assign sdram_a   = adr[12:0];
  assign sdram_cke = cke;
  assign sdram_dm  = 2'b00;
  assign sdram_dq  = dq_oe ? wdata_r : {16{1'bz}};
  assign rdata     = rdata_r;
  assign p0_ack    = ack0;
  assign p1_ack    = ack1;
  assign p0_rvalid = rv0;
  assign p1_rvalid = rv1;

endmodule

// File: doc/sdram_ctrl.md
SDRAM_CTRL -- requirements
Module: sdram_ctrl

Interface
REQ-001 Parameter INIT_CYCLES, default 100: NOP cycles after reset before the first command.
REQ-002 Parameter REFRESH_INTERVAL, default 780: cycles between refresh requests.
REQ-003 Parameter REFRESH_CYCLES, default 4: length of the REFRESH state in cycles, including the command cycle.
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset, with the following ports:
- clock  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- p0_req, p1_req  in  1  port request; held with fields stable until ack.
- p0_we, p1_we  in  1  1 = write, 0 = read.
- p0_addr, p1_addr  in  15  {bank[1:0], row/col[12:0]}.
- p0_wdata, p1_wdata  in  16  write data.
- p0_ack, p1_ack  out  1  one-cycle grant pulse.
- p0_rvalid, p1_rvalid  out  1  one-cycle read-data-valid pulse.
- rdata  out  16  read data, shared by both ports, valid with rvalid.
- sdram_a  out  13  address.
- sdram_ba  out  2  bank.
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins.
- sdram_cke  out  1  clock enable.
- sdram_dm  out  2  data mask.
- sdram_dq  inout  16  data bus.

Function
REQ-005 States SHALL be INIT, IDLE, WRITE, READ1, READ2 and REFRESH.
REQ-006 INIT SHALL hold for INIT_CYCLES cycles with cke=1 and NOP (cs_n=1), then go to IDLE; requests SHALL NOT be acked during INIT.
REQ-007 NOP SHALL be cs_n=ras_n=cas_n=we_n=1; sdram_dm SHALL be 2'b00 at all times.
REQ-008 The controller SHALL never issue PRECHARGE or LOAD MODE; we_n=0 is used only in the WRITE state.
REQ-009 The refresh counter SHALL start at 0 on leaving INIT and count 0..REFRESH_INTERVAL-1, then wrap and set refresh_pending; REFRESH entry SHALL clear refresh_pending.
REQ-010 In IDLE, refresh_pending SHALL take priority over port requests.
REQ-011 If only one port requests, that port SHALL be granted; if both request, the port not granted last SHALL win (round-robin). The last-grant flag SHALL reset to port 1, so port 0 wins the first tie.
REQ-012 A grant SHALL register {ba,a}=addr, wdata and we on the IDLE edge; the granted ack SHALL be high only during the first command cycle.
REQ-013 WRITE SHALL last 1 cycle with cs_n=0, ras_n=1, cas_n=0, we_n=0 and dq driven with wdata, then return to IDLE.
REQ-014 READ1 and READ2 SHALL each hold cs_n=0, ras_n=1, cas_n=0, we_n=1 with dq at high-Z.
REQ-015 rdata SHALL capture sdram_dq on the READ2->IDLE edge, and the granted port's rvalid SHALL pulse for 1 cycle in the following IDLE cycle.
REQ-016 REFRESH SHALL issue cs_n=0, ras_n=0, cas_n=0, we_n=1 in its first cycle, then NOP for REFRESH_CYCLES-1 cycles, then return to IDLE.
REQ-017 sdram_dq SHALL be high-Z in every state except WRITE.
REQ-018 If refresh_pending sets during WRITE or READ, the transaction SHALL complete; REFRESH SHALL follow from IDLE before any further grant.
REQ-019 Latency from req sampled in IDLE: ack in the next cycle; write done after 1 cycle; rvalid 3 cycles after the IDLE grant edge.
REQ-020 A req held after its ack SHALL be treated as a new request, so requesters SHALL deassert req after ack.
REQ-021 rdata SHALL hold its value until the next read capture.

Reset
REQ-022 On reset, the block SHALL enter INIT with: counters=0, refresh_pending=0, cke=0, NOP, a=0, ba=0, dm=0, dq high-Z, acks=0, rvalids=0, rdata=0.
REQ-023 cke SHALL go to 1 in the first cycle after reset deasserts.
REQ-024 Reset asserted mid-transaction SHALL abort it within one edge: no ack, rvalid or write cycle after reset is sampled.

Verification
REQ-025 Init: p0_req=1 from reset release -> no ack and cs_n=1 for 100 cycles; p0_ack in cycle 101.
REQ-026 Write/readback: p0 writes 0xBEEF to 0x0005, then reads 0x0005 -> p0_rvalid=1 with rdata=0xBEEF three cycles after the read grant edge.
REQ-027 Unwritten read: p1 reads 0x1FFF -> p1_rvalid with rdata=0x0F0F (memory model init value).
REQ-028 Contention: both ports hold reads, re-requesting after each ack -> grants alternate p0, p1, p0, p1; no back-to-back grant to the same port while the other waits.
REQ-029 Refresh collision: refresh_pending and p0_req both high in IDLE -> refresh command (ras_n=cas_n=0, we_n=1) first, 3 NOP cycles, then p0_ack.
REQ-030 Reset in READ1 -> next cycle all outputs at reset values, no p0_rvalid, controller in INIT.
